// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the instruction condition against the
// stored architectural flags, gates the decoder's write requests, and holds
// the NZ / CV flag registers with per-group write enables.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  // Stored flags: nz_q = {N, Z}, cv_q = {C, V}
  logic [1:0] nz_q;
  logic [1:0] cv_q;

  logic flag_n, flag_z, flag_c, flag_v;
  logic nz_we, cv_we;

  assign Flags  = {nz_q, cv_q};
  assign flag_n = nz_q[1];
  assign flag_z = nz_q[0];
  assign flag_c = cv_q[1];
  assign flag_v = cv_q[0];

  // Condition decode from stored flags only; ALUFlags never bypasses in
  always_comb begin
    CondEx = 1'b0;
    unique case (cond_e'(Cond))
      CondEq: CondEx = flag_z;
      CondNe: CondEx = ~flag_z;
      CondCs: CondEx = flag_c;
      CondCc: CondEx = ~flag_c;
      CondMi: CondEx = flag_n;
      CondPl: CondEx = ~flag_n;
      CondVs: CondEx = flag_v;
      CondVc: CondEx = ~flag_v;
      CondHi: CondEx = flag_c & ~flag_z;
      CondLs: CondEx = ~flag_c | flag_z;
      CondGe: CondEx = (flag_n == flag_v);
      CondLt: CondEx = (flag_n != flag_v);
      CondGt: CondEx = ~flag_z & (flag_n == flag_v);
      CondLe: CondEx = flag_z | (flag_n != flag_v);
      CondAl: CondEx = 1'b1;
      CondNv: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  // Write enables gated by the condition outcome
  always_comb begin
    PCSrc    = PCS & CondEx;
    RegWrite = RegW & ~NoWrite & CondEx;
    MemWrite = MemW & CondEx;
    nz_we    = FlagW[1] & CondEx;
    cv_we    = FlagW[0] & CondEx;
  end

  // NZ flag register; reset wins over a simultaneous write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_q <= 2'b00;
    end else if (nz_we) begin
      nz_q <= ALUFlags[3:2];
    end
  end

  // CV flag register; reset wins over a simultaneous write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cv_q <= 2'b00;
    end else if (cv_we) begin
      cv_q <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios plus randomized
// traffic checked against a flag/condition reference model.
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int errors;
  int checks;
  logic [3:0] model_flags;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pairs of codes share a base test, odd code is its negation
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    step();
    FlagW = 2'b00;
    model_flags = f;
  endtask

  task automatic test_reset();
    reset = 1'b1; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    #3;
    checks++;
    if (Flags !== 4'b0000) begin
      errors++; $display("FAIL reset_async_flags: got %b want 0000", Flags);
    end
    step();
    checks++;
    if (Flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", Flags);
    end
    // Reset priority over a simultaneous flag write
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    step();
    checks++;
    if (Flags !== 4'b0000) begin
      errors++; $display("FAIL reset_priority: got %b want 0000", Flags);
    end
    FlagW = 2'b00;
    reset = 1'b0;
    model_flags = 4'b0000;
    #1;
    // With flags zero: EQ CS MI VS fail, NE CC PL VC AL pass
    for (int c = 0; c < 8; c++) begin
      Cond = 4'(c);
      #1;
      checks++;
      if (CondEx !== c[0]) begin
        errors++; $display("FAIL post_reset_cond%0d: got %b want %b", c, CondEx, c[0]);
      end
    end
    Cond = 4'b1110;
    #1;
    checks++;
    if (CondEx !== 1'b1) begin
      errors++; $display("FAIL post_reset_al: got %b want 1", CondEx);
    end
  endtask

  task automatic test_basic_gating();
    Cond = 4'b0000; RegW = 1'b1;
    #1;
    checks++;
    if (CondEx !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL eq_gating: got CondEx=%b RegWrite=%b want 0 0", CondEx, RegWrite);
    end
    Cond = 4'b0001;
    #1;
    checks++;
    if (CondEx !== 1'b1 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL ne_gating: got CondEx=%b RegWrite=%b want 1 1", CondEx, RegWrite);
    end
    RegW = 1'b0;
  endtask

  task automatic test_flag_latency();
    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b00; ALUFlags = 4'b0100;
    #1;
    checks++;
    if (CondEx !== 1'b0) begin
      errors++; $display("FAIL no_bypass: got CondEx=%b want 0", CondEx);
    end
    Cond = 4'b1110; FlagW = 2'b11;
    step();
    checks++;
    if (Flags !== 4'b0100) begin
      errors++; $display("FAIL al_load: got %b want 0100", Flags);
    end
    Cond = 4'b0000; FlagW = 2'b00;
    #1;
    checks++;
    if (CondEx !== 1'b1) begin
      errors++; $display("FAIL eq_after_load: got CondEx=%b want 1", CondEx);
    end
    model_flags = 4'b0100;
  endtask

  task automatic test_failed_cond();
    load_flags(4'b0100);
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1011; PCS = 1; MemW = 1; RegW = 1;
    #1;
    checks++;
    if (CondEx !== 1'b0 || PCSrc !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL failed_cond_gates: got CondEx=%b PCSrc=%b MemWrite=%b RegWrite=%b want 0 0 0 0",
               CondEx, PCSrc, MemWrite, RegWrite);
    end
    step();
    checks++;
    if (Flags !== 4'b0100) begin
      errors++; $display("FAIL failed_cond_hold: got %b want 0100", Flags);
    end
    PCS = 0; MemW = 0; RegW = 0; FlagW = 2'b00;
  endtask

  task automatic test_partial_write();
    load_flags(4'b0000);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
    step();
    checks++;
    if (Flags !== 4'b1100) begin
      errors++; $display("FAIL nz_only: got %b want 1100", Flags);
    end
    FlagW = 2'b01; ALUFlags = 4'b0011;
    step();
    checks++;
    if (Flags !== 4'b1111) begin
      errors++; $display("FAIL cv_only: got %b want 1111", Flags);
    end
    FlagW = 2'b00;
    model_flags = 4'b1111;
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        checks++;
        if (CondEx !== model_cond(4'(c), 4'(f))) begin
          errors++;
          $display("FAIL sweep cond=%b flags=%b: got %b want %b", 4'(c), 4'(f), CondEx,
                   model_cond(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    load_flags(4'b1010);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin
      errors++; $display("FAIL async_reset: got %b want 0000", Flags);
    end
    Cond = 4'b1110; NoWrite = 1'b1; RegW = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++; $display("FAIL nowrite: got RegWrite=%b want 0", RegWrite);
    end
    step();
    reset = 1'b0; NoWrite = 1'b0; RegW = 1'b0;
    model_flags = 4'b0000;
  endtask

  task automatic test_random();
    logic exp_ex;
    for (int i = 0; i < 300; i++) begin
      Cond = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW = 2'($urandom_range(0, 3));
      PCS = 1'($urandom_range(0, 1));
      RegW = 1'($urandom_range(0, 1));
      MemW = 1'($urandom_range(0, 1));
      NoWrite = 1'($urandom_range(0, 1));
      #1;
      exp_ex = model_cond(Cond, model_flags);
      checks++;
      if (CondEx !== exp_ex || PCSrc !== (PCS && exp_ex) || MemWrite !== (MemW && exp_ex) ||
          RegWrite !== (RegW && !NoWrite && exp_ex) || Flags !== model_flags) begin
        errors++;
        $display("FAIL random[%0d]: got ex=%b pc=%b rw=%b mw=%b fl=%b want ex=%b pc=%b rw=%b mw=%b fl=%b",
                 i, CondEx, PCSrc, RegWrite, MemWrite, Flags, exp_ex, PCS && exp_ex,
                 RegW && !NoWrite && exp_ex, MemW && exp_ex, model_flags);
      end
      @(posedge clk);
      if (exp_ex && FlagW[1]) model_flags[3:2] = ALUFlags[3:2];
      if (exp_ex && FlagW[0]) model_flags[1:0] = ALUFlags[1:0];
      #1;
    end
    FlagW = 2'b00; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_flags = 4'b0000;
    test_reset();
    test_basic_gating();
    test_flag_latency();
    test_failed_cond();
    test_partial_write();
    test_sweep();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
